sdram_rd_arbiter: RTL and testbench
===================================

Name: sdram_rd_arbiter

Overview:
- Shares the single byte-wide SDRAM read port between two requesters: requester 0 is the cassette player's tape-image fetch, requester 1 is the cartridge/ROM image fetch.
- Each requester issues one-byte reads with a req/ack handshake.
- The arbiter grants requests round-robin, drives sdram_addr/sdram_rd, captures sdram_data after a fixed latency and returns it to the granted requester.
- It sits between the requester blocks and the SDRAM controller's read port.

Parameters:
- ADDR_W, 25, width of SDRAM byte address.
- RD_LATENCY, 1, cycles from the sdram_rd assertion cycle until sdram_data is valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 read request; level, held until ack0.
- addr0  input  ADDR_W  requester 0 byte address; stable while req0 is high.
- ack0  output  1  one-cycle pulse; dout0 valid in this cycle.
- dout0  output  8  data for requester 0; holds last value.
- req1  input  1  requester 1 read request.
- addr1  input  ADDR_W  requester 1 byte address.
- ack1  output  1  one-cycle pulse for requester 1.
- dout1  output  8  data for requester 1; holds last value.
- sdram_addr  output  ADDR_W  read address to SDRAM controller.
- sdram_rd  output  1  one-cycle read strobe.
- sdram_data  input  8  read data from SDRAM controller.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sdram_rd=0; sdram_addr=0; ack0=ack1=0; dout0=dout1=0; busy=0; last_grant=1, so requester 0 wins the first contention; wait counter=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: reqs sampled every cycle.
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch sel, load sdram_addr from the selected addr, update last_grant, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: sdram_rd=1 for exactly this cycle. Load the wait counter with RD_LATENCY-1. Go to WAIT.
- WAIT: sdram_rd=0. When the counter is 0, capture sdram_data into dout[sel] and go to DONE. Otherwise decrement the counter.
  - The capture cycle is exactly RD_LATENCY cycles after the ISSUE cycle.
- DONE: ack[sel]=1 for this one cycle only; the other ack stays 0. Next state is IDLE.
- Latency: req seen in IDLE at cycle T gives sdram_rd at T+1, capture at T+1+RD_LATENCY, and ack at T+2+RD_LATENCY.
  - RD_LATENCY=1 gives req→ack = 3 cycles.
  - Back-to-back throughput is one access per RD_LATENCY+3 cycles, because IDLE is always revisited.
- Requester rules:
  - After ack, the requester drops req, or keeps it high with a new address for the next access.
  - The arbiter re-samples req only in IDLE, so a req still high in the IDLE after ack starts a new access.
- Fairness with both reqs held continuously: grants strictly alternate 0,1,0,1.
- The non-granted requester's dout is never modified, and its ack is never pulsed.
- req dropped mid-transaction: the transaction still completes and ack still pulses; the requester ignores it.
- addr changing mid-transaction: no effect, since sdram_addr was latched at grant.
- sdram_addr holds its value after the transaction; it changes only at grant.
- reset_n asserted mid-transaction: immediate return to the reset state. No ack is issued; sdram_rd drops asynchronously.

Test Plan:
- Reset, then req0=1, addr0=0x000010, sdram_data returns 0x55 one cycle after sdram_rd. Required: sdram_rd high in exactly one cycle with sdram_addr=0x000010; ack0 pulses 3 cycles after req0 is seen; dout0=0x55; ack1 stays 0.
- req0 and req1 both rise in the same cycle and are held, addr0=0x100, addr1=0x200. Required: issue order 0x100, 0x200, 0x100, 0x200; acks alternate ack0, ack1, ack0, ack1.
- RD_LATENCY=4 with SDRAM model latency 4: req1 at addr 0x1FFFFFF, data 0xC3. Required: capture 4 cycles after sdram_rd; ack1 at T+6; dout1=0xC3; dout0 unchanged.
- req0 high; change addr0 and drop req0 during WAIT. Required: sdram_addr keeps the original address; ack0 still pulses once; then IDLE, and busy=0.
- reset_n pulled low during WAIT. Required: sdram_rd=0, busy=0, no ack; after release, a fresh req0 completes normally with requester 0 winning contention.
- Cassette-style stream: req0 held for 16 sequential addresses while req1 idle. Required: 16 acks, one every 4 cycles with RD_LATENCY=1; dout0 matches image bytes in order.

Source files
------------

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: shares the byte-wide SDRAM read port between two
// requesters (0 = tape-image fetch, 1 = cartridge/ROM fetch). Requests are
// granted round-robin. The arbiter issues a one-cycle read strobe, captures
// the read data RD_LATENCY cycles later and returns it with a one-cycle ack.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req0/addr0/ack0/dout0 requester 0 handshake, address, ack pulse, data
//   req1/addr1/ack1/dout1 requester 1 handshake, address, ack pulse, data
//   sdram_addr/sdram_rd   read address and one-cycle strobe to the controller
//   sdram_data            read data from the controller
//   busy                  high whenever the arbiter is not idle
module sdram_rd_arbiter #(
   parameter int unsigned ADDR_W     = 25,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   output logic [7:0]        dout0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack1,
   output logic [7:0]        dout1,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              sdram_rd,
   input  logic [7:0]        sdram_data,
   output logic              busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                sel_q, sel_d;
   logic                last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   sdram_addr_q, sdram_addr_d;
   logic                sdram_rd_q, sdram_rd_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [7:0]          dout0_q, dout0_d;
   logic [7:0]          dout1_q, dout1_d;
   logic                busy_q, busy_d;
   logic                grant_c;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         sdram_addr_q <= '0;
         sdram_rd_q   <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         dout0_q      <= '0;
         dout1_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         sdram_addr_q <= sdram_addr_d;
         sdram_rd_q   <= sdram_rd_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         dout0_q      <= dout0_d;
         dout1_q      <= dout1_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic. Pulsed outputs are computed one cycle ahead so the
   // registered strobe lines up with ISSUE and the ack lines up with DONE.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      sdram_addr_d = sdram_addr_q;
      sdram_rd_d   = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      dout0_d      = dout0_q;
      dout1_d      = dout1_q;
      grant_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // On contention the requester that did not win last time goes.
            grant_c = (req0 && req1) ? ~last_grant_q : req1;
            if (req0 || req1) begin
               sel_d        = grant_c;
               last_grant_d = grant_c;
               sdram_addr_d = grant_c ? addr1 : addr0;
               sdram_rd_d   = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_W'(RD_LATENCY - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (sel_q) begin
                  dout1_d = sdram_data;
                  ack1_d  = 1'b1;
               end else begin
                  dout0_d = sdram_data;
                  ack0_d  = 1'b1;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign dout0      = dout0_q;
   assign dout1      = dout1_q;
   assign sdram_addr = sdram_addr_q;
   assign sdram_rd   = sdram_rd_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Testbench for sdram_rd_arbiter: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=4, each fed by a fixed-latency SDRAM read model. Stimulus pushes
// expected issues/acks into queues; monitors pop and compare on sdram_rd/ack.
module tb_sdram_rd_arbiter;

   localparam int unsigned AW = 25;
   localparam int unsigned L1 = 1;
   localparam int unsigned L4 = 4;

   logic clk = 1'b0;
   logic reset_n;

   logic          req0, req1, ack0, ack1, sdram_rd, busy;
   logic [AW-1:0] addr0, addr1, sdram_addr;
   logic [7:0]    dout0, dout1, sdram_data;

   logic          req0_b, req1_b, ack0_b, ack1_b, sdram_rd_b, busy_b;
   logic [AW-1:0] addr0_b, addr1_b, sdram_addr_b;
   logic [7:0]    dout0_b, dout1_b, sdram_data_b;

   always #5 clk = ~clk;

   sdram_rd_arbiter #(.ADDR_W(AW), .RD_LATENCY(L1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .addr0(addr0), .ack0(ack0), .dout0(dout0),
      .req1(req1), .addr1(addr1), .ack1(ack1), .dout1(dout1),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_data(sdram_data),
      .busy(busy)
   );

   sdram_rd_arbiter #(.ADDR_W(AW), .RD_LATENCY(L4)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b), .dout0(dout0_b),
      .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b), .dout1(dout1_b),
      .sdram_addr(sdram_addr_b), .sdram_rd(sdram_rd_b), .sdram_data(sdram_data_b),
      .busy(busy_b)
   );

   // SDRAM contents: a few fixed bytes plus a 16-byte tape image at 0x400.
   logic [7:0] img [16];

   function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
      if (a >= 25'h400 && a < 25'h410) return img[a[3:0]];
      case (a)
         25'h0000010: return 8'h55;
         25'h0000100: return 8'hA1;
         25'h0000200: return 8'hB2;
         25'h1FFFFFF: return 8'hC3;
         default:     return 8'hEE;
      endcase
   endfunction

   // Fixed-latency read models: data is present only in the capture cycle.
   logic [7:0] pipe_a [L1];
   logic [7:0] pipe_b [L4];
   always @(posedge clk) begin
      pipe_a[0] <= sdram_rd ? mem_rd(sdram_addr) : 8'h00;
      pipe_b[0] <= sdram_rd_b ? mem_rd(sdram_addr_b) : 8'h00;
      for (int i = 1; i < int'(L4); i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign sdram_data   = pipe_a[L1-1];
   assign sdram_data_b = pipe_b[L4-1];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } ack_t;

   ack_t          exp_ack_a[$], exp_ack_b[$];
   logic [AW-1:0] exp_iss_a[$], exp_iss_b[$];
   bit            stream_on = 1'b0;
   bit            stream_first = 1'b1;

   // Monitor for the RD_LATENCY=1 instance.
   initial begin
      ack_t        e;
      bit          prev_rd = 1'b0;
      int unsigned rd_cyc = 0, last_ack = 0;
      logic [7:0]  hold0 = 8'h00, hold1 = 8'h00;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (sdram_rd) begin
               chk("rd_single_cycle", 32'(prev_rd), 32'(0));
               if (exp_iss_a.size() == 0) chk("unexpected_rd", 32'(1), 32'(0));
               else chk("issue_addr", 32'(sdram_addr), 32'(exp_iss_a.pop_front()));
               rd_cyc = cyc;
            end
            if (ack0 || ack1) begin
               if (exp_ack_a.size() == 0) begin
                  chk("unexpected_ack", 32'({ack1, ack0}), 32'(0));
               end else begin
                  e = exp_ack_a.pop_front();
                  chk("ack_id", 32'({ack1, ack0}), e.id ? 32'(2) : 32'(1));
                  chk("dout_sel", 32'(e.id ? dout1 : dout0), 32'(e.data));
                  chk("dout_other_held", 32'(e.id ? dout0 : dout1), 32'(e.id ? hold0 : hold1));
                  chk("rd_to_ack", cyc - rd_cyc, 32'(L1 + 1));
                  if (stream_on) begin
                     if (!stream_first) chk("stream_spacing", cyc - last_ack, 32'(4));
                     stream_first = 1'b0;
                  end
                  last_ack = cyc;
               end
            end
         end
         prev_rd = sdram_rd;
         hold0   = dout0;
         hold1   = dout1;
      end
   end

   // Monitor for the RD_LATENCY=4 instance.
   initial begin
      ack_t        e;
      int unsigned rd_cyc = 0;
      logic [7:0]  hold0 = 8'h00, hold1 = 8'h00;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (sdram_rd_b) begin
               if (exp_iss_b.size() == 0) chk("b_unexpected_rd", 32'(1), 32'(0));
               else chk("b_issue_addr", 32'(sdram_addr_b), 32'(exp_iss_b.pop_front()));
               rd_cyc = cyc;
            end
            if (ack0_b || ack1_b) begin
               if (exp_ack_b.size() == 0) begin
                  chk("b_unexpected_ack", 32'({ack1_b, ack0_b}), 32'(0));
               end else begin
                  e = exp_ack_b.pop_front();
                  chk("b_ack_id", 32'({ack1_b, ack0_b}), e.id ? 32'(2) : 32'(1));
                  chk("b_dout_sel", 32'(e.id ? dout1_b : dout0_b), 32'(e.data));
                  chk("b_dout_other_held", 32'(e.id ? dout0_b : dout1_b),
                      32'(e.id ? hold0 : hold1));
                  chk("b_rd_to_ack", cyc - rd_cyc, 32'(L4 + 1));
               end
            end
         end
         hold0 = dout0_b;
         hold1 = dout1_b;
      end
   end

   task automatic wait_ack(input bit on_b, input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (on_b ? (ack0_b || ack1_b) : (ack0 || ack1)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("ack_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_rd(input int budget);
      bit seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sdram_rd) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("rd_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int unsigned t;
      img = '{8'h4E, 8'h45, 8'h53, 8'h20, 8'h54, 8'h41, 8'h50, 8'h45,
              8'h00, 8'hFF, 8'h13, 8'h37, 8'hA5, 8'h5A, 8'h01, 8'h80};
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      req0_b = 1'b0; req1_b = 1'b0; addr0_b = '0; addr1_b = '0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_sdram_rd", 32'(sdram_rd), 32'(0));
      chk("rst_sdram_addr", 32'(sdram_addr), 32'(0));
      chk("rst_acks", 32'({ack1, ack0}), 32'(0));
      chk("rst_dout0", 32'(dout0), 32'(0));
      chk("rst_dout1", 32'(dout1), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      reset_n = 1'b1;

      // Single read by requester 0.
      @(negedge clk);
      exp_iss_a.push_back(25'h10);
      exp_ack_a.push_back('{id: 1'b0, data: 8'h55});
      addr0 = 25'h10;
      req0  = 1'b1;
      t     = cyc;
      wait_ack(1'b0, 20);
      chk("req_to_ack0", cyc - t, 32'(3));
      req0 = 1'b0;
      @(negedge clk);
      chk("idle_after_single", 32'(busy), 32'(0));

      // Contention: both held, grants must alternate starting with 0.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         exp_iss_a.push_back(25'h100);
         exp_ack_a.push_back('{id: 1'b0, data: 8'hA1});
         exp_iss_a.push_back(25'h200);
         exp_ack_a.push_back('{id: 1'b1, data: 8'hB2});
      end
      addr0 = 25'h100; addr1 = 25'h200;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) wait_ack(1'b0, 20);
      req0 = 1'b0; req1 = 1'b0;

      // RD_LATENCY=4 instance, requester 1 at the top address.
      @(negedge clk);
      exp_iss_b.push_back(25'h1FFFFFF);
      exp_ack_b.push_back('{id: 1'b1, data: 8'hC3});
      addr1_b = 25'h1FFFFFF;
      req1_b  = 1'b1;
      t       = cyc;
      wait_ack(1'b1, 30);
      chk("b_req_to_ack1", cyc - t, 32'(6));
      chk("b_dout0_untouched", 32'(dout0_b), 32'(0));
      req1_b = 1'b0;

      // Drop req0 and change addr0 while the read is in flight.
      @(negedge clk);
      exp_iss_a.push_back(25'h100);
      exp_ack_a.push_back('{id: 1'b0, data: 8'hA1});
      addr0 = 25'h100;
      req0  = 1'b1;
      wait_rd(20);
      @(negedge clk);
      addr0 = 25'h200;
      req0  = 1'b0;
      wait_ack(1'b0, 20);
      chk("addr_latched", 32'(sdram_addr), 32'(25'h100));
      @(negedge clk);
      chk("idle_after_drop", 32'(busy), 32'(0));
      chk("ack_single_pulse", 32'({ack1, ack0}), 32'(0));
      repeat (3) @(negedge clk);
      chk("addr_held_after", 32'(sdram_addr), 32'(25'h100));

      // Reset asserted during WAIT aborts the access with no ack.
      exp_iss_a.push_back(25'h10);
      addr0 = 25'h10;
      req0  = 1'b1;
      wait_rd(20);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_sdram_rd", 32'(sdram_rd), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_ack", 32'({ack1, ack0}), 32'(0));
      req0 = 1'b0;
      @(negedge clk);
      chk("abort_dout0", 32'(dout0), 32'(0));
      reset_n = 1'b1;
      @(negedge clk);
      exp_iss_a.push_back(25'h100);
      exp_ack_a.push_back('{id: 1'b0, data: 8'hA1});
      exp_iss_a.push_back(25'h200);
      exp_ack_a.push_back('{id: 1'b1, data: 8'hB2});
      addr0 = 25'h100; addr1 = 25'h200;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b0, 20);
      req0 = 1'b0;
      wait_ack(1'b0, 20);
      req1 = 1'b0;

      // Cassette stream: 16 sequential bytes, one ack every 4 cycles.
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         exp_iss_a.push_back(AW'(25'h400 + i));
         exp_ack_a.push_back('{id: 1'b0, data: img[i]});
      end
      stream_first = 1'b1;
      stream_on    = 1'b1;
      addr0 = 25'h400;
      req0  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wait_ack(1'b0, 20);
         if (i < 15) addr0 = AW'(25'h401 + i);
         else req0 = 1'b0;
      end
      @(negedge clk);
      stream_on = 1'b0;

      repeat (8) @(negedge clk);
      chk("iss_queue_drained", 32'(exp_iss_a.size() + exp_iss_b.size()), 32'(0));
      chk("ack_queue_drained", 32'(exp_ack_a.size() + exp_ack_b.size()), 32'(0));
      chk("final_busy", 32'({busy_b, busy}), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
